// File: rtl/led_bank_scheduler.sv
// -----------------------------------------------------------------------------
// led_bank_scheduler
//
// Shares the 8 user LEDs between four pattern requesters and a free-running
// count display. Everything runs on the single board clock; a one-cycle
// clock-enable (tick) paces all visible-rate activity.
//
// A round-robin arbiter grants the bank to one requester at a time. The
// winner's pattern and display length are captured at the grant edge, and the
// bank is held for that many ticks regardless of later input changes. When
// the display ends, the requester gets a one-cycle done pulse and the bank
// returns to the free-running count.
//
// Parameters
//   TICK_DIV  CLK50MHz cycles per visible tick (>= 2).
//
// Ports
//   CLK50MHz  in   board clock, the only clock in the block
//   RST       in   asynchronous, active-high reset
//   req       in   [3:0]  request, one bit per requester
//   pattern   in   [31:0] requester i pattern on [8i+7:8i]
//   hold      in   [15:0] requester i length in ticks on [4i+3:4i] (0 -> 1)
//   gnt       out  [3:0]  one-hot grant (registered)
//   done      out  [3:0]  one-cycle end-of-display pulse (registered)
//   tick      out         one-cycle visible-rate strobe (registered)
//   LED       out  [7:0]  LED bank drive, bit 0 -> LED0 (registered)
// -----------------------------------------------------------------------------
module led_bank_scheduler #(
    parameter int TICK_DIV = 8388608
) (
    input  logic        CLK50MHz,
    input  logic        RST,
    input  logic [3:0]  req,
    input  logic [31:0] pattern,
    input  logic [15:0] hold,
    output logic [3:0]  gnt,
    output logic [3:0]  done,
    output logic        tick,
    output logic [7:0]  LED
);

    localparam int CNT_W = $clog2(TICK_DIV);

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    // tick is a register, so it is loaded one count early to be high
    // exactly while the counter sits at TICK_LAST.
    localparam logic [CNT_W-1:0] TICK_PRE  = CNT_W'(TICK_DIV - 2);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SHOW = 1'b1;

    logic [CNT_W-1:0] tick_cnt;
    logic [7:0]       free_cnt;
    logic [7:0]       free_cnt_nxt;
    logic [0:0]       state;
    logic [1:0]       ptr;
    logic [1:0]       win;
    logic [7:0]       win_pat;
    logic [3:0]       win_hold;
    logic [7:0]       cur_pat;
    logic [3:0]       remain;

    // Round-robin pick: search from (p+1) upward with wrap; p itself is
    // examined last, so a lone persistent requester can win again.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] sel;
        logic       found;
        sel   = p;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = p + 2'(k);
            if (!found && r[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // A zero display length still shows the pattern for one tick.
    function automatic logic [3:0] hold_len(input logic [3:0] h);
        return (h == 4'd0) ? 4'd1 : h;
    endfunction

    always_comb begin
        win      = rr_pick(req, ptr);
        win_pat  = pattern[7:0];
        win_hold = hold[3:0];
        case (win)
            2'd0: begin
                win_pat  = pattern[7:0];
                win_hold = hold[3:0];
            end
            2'd1: begin
                win_pat  = pattern[15:8];
                win_hold = hold[7:4];
            end
            2'd2: begin
                win_pat  = pattern[23:16];
                win_hold = hold[11:8];
            end
            default: begin
                win_pat  = pattern[31:24];
                win_hold = hold[15:12];
            end
        endcase
    end

    // The count advances on the edge that closes a tick cycle, in any state.
    assign free_cnt_nxt = tick ? free_cnt + 8'd1 : free_cnt;

    // ---- tick generator and free-running count ----
    always_ff @(posedge CLK50MHz or posedge RST) begin
        if (RST) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
            free_cnt <= 8'h00;
        end else begin
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
            tick     <= (tick_cnt == TICK_PRE);
            free_cnt <= free_cnt_nxt;
        end
    end

    // ---- arbitration and display FSM ----
    always_ff @(posedge CLK50MHz or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            ptr     <= 2'd3;
            gnt     <= 4'b0000;
            done    <= 4'b0000;
            cur_pat <= 8'h00;
            remain  <= 4'd0;
            LED     <= 8'h00;
        end else begin
            done <= 4'b0000;
            case (state)
                IDLE: begin
                    if (req != 4'b0000) begin
                        state   <= SHOW;
                        gnt     <= 4'b0001 << win;
                        ptr     <= win;
                        cur_pat <= win_pat;
                        remain  <= hold_len(win_hold);
                        LED     <= win_pat;
                    end else begin
                        // LED is loaded with the post-edge count so it
                        // tracks free_cnt without a cycle of lag.
                        LED <= free_cnt_nxt;
                    end
                end
                default: begin
                    // Inputs are not looked at here: the grant is
                    // non-preemptive and the display uses cur_pat only.
                    LED <= cur_pat;
                    if (tick) begin
                        if (remain == 4'd1) begin
                            done  <= gnt;
                            gnt   <= 4'b0000;
                            state <= IDLE;
                            LED   <= free_cnt_nxt;
                        end else begin
                            remain <= remain - 4'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_bank_scheduler.sv
module tb_led_bank_scheduler;

    logic        CLK50MHz;
    logic        RST;
    logic [3:0]  req;
    logic [31:0] pattern;
    logic [15:0] hold;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        tick;
    logic [7:0]  LED;

    led_bank_scheduler #(.TICK_DIV(4)) dut (
        .CLK50MHz (CLK50MHz),
        .RST      (RST),
        .req      (req),
        .pattern  (pattern),
        .hold     (hold),
        .gnt      (gnt),
        .done     (done),
        .tick     (tick),
        .LED      (LED)
    );

    initial CLK50MHz = 1'b0;
    always #10 CLK50MHz = ~CLK50MHz;

    // One expected display: who wins, what it shows, the edge (counted from
    // reset release) at which gnt appears and the edge after which done pulses.
    typedef struct {
        int         idx;
        logic [7:0] pat;
        int         g;
        int         d;
    } rec_t;

    rec_t exp_q[$];
    rec_t cur;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   k      = 0;   // edges since reset release (monitor owned)
    bit   act    = 0;   // a display is in progress (monitor owned)
    bit   mon_en = 0;
    int   mptr   = 3;   // model's last winner

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h, want %0h", nm, k, got, want);
        end
    endtask

    task automatic fail_stop(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait bound expired", nm);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    endtask

    // With TICK_DIV=4 a tick edge is every 4th edge, so the count after
    // edge k is simply k/4.
    function automatic logic [7:0] free_model(input int kk);
        return 8'((kk / 4) % 256);
    endfunction

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [3:0] oh;
        forever begin
            @(posedge CLK50MHz);
            #1;
            if (!mon_en) begin
                k   = 0;
                act = 0;
                continue;
            end
            k++;
            chk("tick", 32'(tick), 32'((k % 4) == 3));
            if (!act && (gnt != 4'b0 || (exp_q.size() > 0 && k >= exp_q[0].g))) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_gnt", 32'(gnt), 32'h0);
                end else begin
                    cur = exp_q.pop_front();
                    oh  = 4'b0001 << cur.idx;
                    chk("gnt_edge", k, cur.g);
                    chk("gnt", 32'(gnt), 32'(oh));
                    chk("led_pat", 32'(LED), 32'(cur.pat));
                    chk("done_at_gnt", 32'(done), 32'h0);
                    act = 1;
                end
            end else if (!act) begin
                chk("idle", {16'h0, gnt, LED, done}, {16'h0, 4'b0, free_model(k), 4'b0});
            end else if (k < cur.d) begin
                oh = 4'b0001 << cur.idx;
                chk("show", {16'h0, gnt, LED, done}, {16'h0, oh, cur.pat, 4'b0});
            end else begin
                oh = 4'b0001 << cur.idx;
                chk("done", 32'(done), 32'(oh));
                chk("gnt_clr", 32'(gnt), 32'h0);
                chk("led_ret", 32'(LED), 32'(free_model(k)));
                act = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called at a negedge with the bank idle. keep=1: req held until ngr
    // grants have been scheduled. keep=0: each requester drops req (and
    // scrambles its own lane) once granted; ngr is the number of requesters.
    task automatic run_batch(input logic [3:0] set, input logic [31:0] pv,
                             input logic [15:0] hv, input bit keep,
                             input int ngr, output bit tmo);
        int         t;
        int         p;
        int         idx;
        int         h;
        int         cnt;
        rec_t       r;
        logic [3:0] live;
        t    = k + 1;
        p    = mptr;
        live = set;
        cnt  = keep ? ngr : $countones(set);
        for (int n = 0; n < cnt; n++) begin
            idx = p;
            for (int j = 4; j >= 1; j--)
                if (live[(p + j) % 4]) idx = (p + j) % 4;
            if (!keep) live[idx] = 1'b0;
            h     = int'(hv[4*idx +: 4]);
            if (h == 0) h = 1;
            r.idx = idx;
            r.pat = pv[8*idx +: 8];
            r.g   = t;
            r.d   = (t / 4 + 1) * 4 + 4 * (h - 1);
            exp_q.push_back(r);
            t = r.d + 1;
            p = idx;
        end
        mptr    = p;
        pattern = pv;
        hold    = hv;
        req     = set;
        tmo     = 0;
        for (int c = 0; c <= 2000; c++) begin
            @(negedge CLK50MHz);
            if (exp_q.size() == 0 && !act) break;
            if (c == 2000) tmo = 1;
            if (keep) begin
                if (exp_q.size() == 0) req = 4'b0;
            end else begin
                req = req & ~gnt;
            end
            for (int i = 0; i < 4; i++)
                if (!req[i]) begin
                    pattern[8*i +: 8] = 8'($urandom);
                    hold[4*i +: 4]    = 4'($urandom);
                end
        end
        req = 4'b0;
    endtask

    task automatic random_batches(input int nb);
        bit tmo;
        for (int b = 0; b < nb; b++) begin
            run_batch(4'($urandom_range(1, 15)), $urandom, 16'($urandom),
                      bit'($urandom_range(0, 1)), $urandom_range(1, 6), tmo);
            if (tmo) fail_stop("batch_drain");
            repeat ($urandom_range(0, 4)) @(negedge CLK50MHz);
        end
    endtask

    initial begin
        bit tmo;
        bit got;
        int nt;
        RST     = 1'b1;
        req     = 4'b0;
        pattern = 32'h0;
        hold    = 16'h0;
        repeat (3) @(posedge CLK50MHz);
        #1;
        chk("rst_led", 32'(LED), 32'h0);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        @(negedge CLK50MHz);
        RST    = 1'b0;
        mon_en = 1;

        // free-running count through a full 8-bit wrap
        repeat (1030) @(negedge CLK50MHz);

        // round-robin with req held: 0,1,2,3,0
        run_batch(4'b1111, 32'h44332211, 16'h1111, 1, 5, tmo);
        if (tmo) fail_stop("rr_drain");
        // single grant, A5 for 3 ticks
        run_batch(4'b0100, 32'h00A50000, 16'h0300, 0, 0, tmo);
        if (tmo) fail_stop("single_drain");
        // hold 0 shows for one tick
        run_batch(4'b0010, 32'h00005A00, 16'h0000, 0, 0, tmo);
        if (tmo) fail_stop("hold0_drain");
        // pattern/hold changed and req dropped mid-display
        run_batch(4'b0100, 32'h00C30000, 16'h0400, 0, 0, tmo);
        if (tmo) fail_stop("nopreempt_drain");

        random_batches(30);

        // reset in the middle of a hold=5 display
        mon_en = 0;
        @(negedge CLK50MHz);
        pattern[15:8] = 8'h3C;
        hold[7:4]     = 4'd5;
        req           = 4'b0010;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge CLK50MHz);
            if (gnt != 4'b0) got = 1;
        end
        if (!got) fail_stop("rst_grant_wait");
        chk("pre_rst_gnt", 32'(gnt), 32'h2);
        chk("pre_rst_led", 32'(LED), 32'h3C);
        req = 4'b0;
        nt  = 0;
        for (int c = 0; c < 40 && nt < 2; c++) begin
            @(negedge CLK50MHz);
            if (tick) nt++;
        end
        if (nt < 2) fail_stop("rst_tick_wait");
        chk("mid_show_gnt", 32'(gnt), 32'h2);
        RST = 1'b1;
        #1;
        chk("async_gnt", 32'(gnt), 32'h0);
        chk("async_led", 32'(LED), 32'h0);
        chk("async_done", 32'(done), 32'h0);
        chk("async_tick", 32'(tick), 32'h0);
        repeat (3) begin
            @(posedge CLK50MHz);
            #1;
            chk("rst_no_done", {28'h0, done}, 32'h0);
            chk("rst_led_hold", 32'(LED), 32'h0);
        end
        @(negedge CLK50MHz);
        RST    = 1'b0;
        mon_en = 1;
        mptr   = 3;
        run_batch(4'b1000, 32'h96000000 | (pattern & 32'h00FFFFFF),
                  16'h2000 | (hold & 16'h0FFF), 0, 0, tmo);
        if (tmo) fail_stop("post_rst_drain");

        random_batches(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1800000;
        n_cmp++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
